mem_master: RTL and testbench
=============================

Name: mem_master

Overview:
- Initiator for the memory valid/ready transaction interface. It is the other end of the `memory` responder's valid / wr_rd / addr / wdata / ready / rdata handshake.
- Accepts write/read commands from an upstream client and buffers them in a small command FIFO.
- Issues the buffered commands one at a time on the memory interface and returns read data, or a timeout error, on a response port with backpressure.
- Used as the synthesizable stimulus engine in front of the memory block and as a reusable master in larger subsystems.

Parameters:
- WIDTH, 16, data width of wdata/rdata.
- DEPTH, 16, memory depth in words (documentation only; no addr range check).
- ADDR_WIDTH, 4, address width.
- FIFO_DEPTH, 4, command FIFO entries; power of 2, ≥2.
- TIMEOUT, 64, max cycles to wait for ready before aborting a transaction.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- cmd_valid  in  1  client command present.
- cmd_ready  out  1  FIFO can accept (not full).
- cmd_wr_rd  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_WIDTH  command address.
- cmd_wdata  in  WIDTH  write data (ignored for reads).
- valid  out  1  memory request valid.
- wr_rd  out  1  memory request type.
- addr  out  ADDR_WIDTH  memory request address.
- wdata  out  WIDTH  memory write data.
- ready  in  1  memory completion.
- rdata  in  WIDTH  memory read data, valid when ready=1 on a read.
- rsp_valid  out  1  response pending.
- rsp_ready  in  1  client takes response.
- rsp_wr_rd  out  1  type of completed command.
- rsp_rdata  out  WIDTH  captured read data; 0 for writes and errors.
- rsp_err  out  1  transaction aborted by timeout.
- busy  out  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- Reset (rst=0, async):
  - FIFO emptied; FSM to IDLE.
  - valid, wr_rd, addr, wdata, rsp_valid, rsp_wr_rd, rsp_rdata, rsp_err, busy all 0.
  - cmd_ready=1 one cycle after rst deasserts; cmd_ready=0 while rst=0.
  - A reset mid-transaction drops valid immediately; no response is produced.
- Command push: on posedge when cmd_valid && cmd_ready. Entry = {wr_rd, addr, wdata}. cmd_ready = !full.
- Simultaneous push and pop when full: pop frees the slot next cycle only. cmd_ready is computed from registered full with no bypass.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - If the FIFO is non-empty and no response is pending, pop the head.
  - Register valid=1 plus wr_rd/addr/wdata; clear the timeout counter; go to REQ.
  - Pop-to-valid latency is 1 cycle. A command pushed into an empty FIFO at edge N shows valid=1 after edge N+1.
- REQ:
  - valid, wr_rd, addr, wdata are held stable until completion.
  - Transfer completes at the posedge where valid && ready. rdata is sampled at that edge if wr_rd=0.
  - Next: valid=0; rsp_valid=1, rsp_wr_rd=wr_rd, rsp_rdata = read ? rdata : 0, rsp_err=0; go to RESP.
  - Timeout counter increments each REQ cycle with ready=0. At count==TIMEOUT-1 with no ready: valid=0, rsp_valid=1, rsp_err=1, rsp_rdata=0; go to RESP.
  - ready=1 on the same edge as the timeout takes priority: normal completion.
- RESP:
  - Response outputs are held stable while rsp_valid && !rsp_ready.
  - On rsp_valid && rsp_ready: rsp_valid=0, rsp_err=0; go to IDLE.
  - No back-to-back issue: minimum 3 cycles per transaction (issue, complete, accept).
- valid is never asserted in RESP.
- ready while valid=0 is ignored.
- Write data and address are never changed while valid=1.
- busy = (FIFO count != 0) || (state != IDLE).
- Command order is preserved; responses return in command order.

Test Plan:
- Reset then single write (cmd_wr_rd=1, addr=3, wdata=16'hA5A5), memory ready after 2 cycles -> valid held 2 cycles with addr=3; one response rsp_valid=1, rsp_wr_rd=1, rsp_err=0, rsp_rdata=0.
- Write addr=5 data=16'h1234 then read addr=5 with the memory model -> read response rsp_rdata=16'h1234, responses in order.
- Push 5 commands back-to-back with ready held 0 for 10 cycles -> cmd_ready=0 after 4 accepted; the 5th is accepted only after the first pop; all 5 complete.
- Read with ready never asserted, TIMEOUT=64 -> valid=1 for exactly 64 cycles, then rsp_err=1, rsp_rdata=0; the next queued command issues after rsp_ready.
- rsp_ready held 0 for 8 cycles after a read completes -> rsp outputs stable, valid stays 0, FIFO holds the next command; it issues 1 cycle after acceptance.
- Assert rst=0 while valid=1 in REQ -> valid, rsp_valid, busy = 0 asynchronously; after release cmd_ready=1 and FIFO empty.

Source files
------------

// File: rtl/mem_master.sv
// mem_master: buffers client commands in a small FIFO and issues them one at a time
// on a valid/ready memory interface, returning read data or a timeout error in order.
module mem_master #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr_rd,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [WIDTH-1:0]      cmd_wdata,
    output logic                  valid,
    output logic                  wr_rd,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [WIDTH-1:0]      wdata,
    input  logic                  ready,
    input  logic [WIDTH-1:0]      rdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_wr_rd,
    output logic [WIDTH-1:0]      rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int ENT_W = 1 + ADDR_WIDTH + WIDTH;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

    // DEPTH only documents the memory size; reject one the address bus cannot reach.
    if (DEPTH > (1 << ADDR_WIDTH)) begin : g_depth_check
        $error("mem_master: DEPTH exceeds address space");
    end

    state_t                  state_q, state_d;
    logic [ENT_W-1:0]        ent_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    cmd_ready_q;
    logic                    valid_q, valid_d, wr_rd_q, wr_rd_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [WIDTH-1:0]        wdata_q, wdata_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic                    rsp_valid_q, rsp_valid_d, rsp_wr_rd_q, rsp_wr_rd_d;
    logic [WIDTH-1:0]        rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    busy_q;
    logic                    push_s, pop_s;
    logic [ENT_W-1:0]        head_s;

    assign push_s = cmd_valid && cmd_ready_q;
    assign head_s = ent_q[rd_ptr_q];

    // Transaction sequencer: issue from FIFO head, wait for ready or timeout, hand back response.
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        wr_rd_d     = wr_rd_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        tmo_d       = tmo_q;
        rsp_valid_d = rsp_valid_q;
        rsp_wr_rd_d = rsp_wr_rd_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        pop_s       = 1'b0;
        case (state_q)
            IDLE: begin
                if ((count_q != '0) && !rsp_valid_q) begin
                    pop_s                      = 1'b1;
                    valid_d                    = 1'b1;
                    {wr_rd_d, addr_d, wdata_d} = head_s;
                    tmo_d                      = '0;
                    state_d                    = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (ready) begin
                    valid_d     = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_wr_rd_d = wr_rd_q;
                    rsp_rdata_d = wr_rd_q ? '0 : rdata;
                    rsp_err_d   = 1'b0;
                    state_d     = RESP;
                end else if (tmo_q == TMO_LAST) begin
                    valid_d     = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_wr_rd_d = wr_rd_q;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = RESP;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                valid_d     = 1'b0;
                rsp_valid_d = 1'b0;
                rsp_err_d   = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // FIFO pointer and occupancy bookkeeping.
    always_comb begin
        wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
    end

    // FIFO storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else if (push_s) begin
            ent_q[wr_ptr_q] <= {cmd_wr_rd, cmd_addr, cmd_wdata};
        end
    end

    // State and registered outputs; cmd_ready stays low until the first edge after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cmd_ready_q <= 1'b0;
            valid_q     <= 1'b0;
            wr_rd_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            tmo_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_wr_rd_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cmd_ready_q <= (count_d != FULL_CNT);
            valid_q     <= valid_d;
            wr_rd_q     <= wr_rd_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            tmo_q       <= tmo_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_wr_rd_q <= rsp_wr_rd_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= (count_d != '0) || (state_d != IDLE);
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign valid     = valid_q;
    assign wr_rd     = wr_rd_q;
    assign addr      = addr_q;
    assign wdata     = wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_wr_rd = rsp_wr_rd_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master: behavioural memory responder plus an in-order
// response scoreboard fed from the command stream.
module tb_mem_master;
    localparam int W  = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_wr_rd = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [W-1:0]  cmd_wdata = '0;
    logic          valid, wr_rd, ready = 1'b0;
    logic [AW-1:0] addr;
    logic [W-1:0]  wdata, rdata = '0;
    logic          rsp_valid, rsp_ready = 1'b1, rsp_wr_rd, rsp_err, busy;
    logic [W-1:0]  rsp_rdata;

    typedef struct {
        logic         wr;
        logic [W-1:0] data;
        logic         err;
    } exp_t;

    exp_t         exp_q [$];
    exp_t         mon_e;
    int           n_vec = 0, n_err = 0;
    int           mem_lat = 1, vcnt = 0, run_cnt = 0, last_run = 0;
    bit           mem_stall = 1'b0;
    logic [W-1:0] mdl_mem [16];
    logic [W-1:0] ref_mem [16];
    bit           held = 1'b0;
    logic         s_wr, s_err;
    logic [W-1:0] s_data;
    int           waited;

    mem_master #(.WIDTH(W), .DEPTH(16), .ADDR_WIDTH(AW), .FIFO_DEPTH(4), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr_rd(cmd_wr_rd),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .valid(valid), .wr_rd(wr_rd), .addr(addr), .wdata(wdata),
        .ready(ready), .rdata(rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr_rd(rsp_wr_rd),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one command until accepted; queue its expected response.
    task automatic push_cmd(input logic wr, input logic [AW-1:0] a, input logic [W-1:0] d,
                            input logic err, output int wcnt);
        exp_t e;
        wcnt      = 0;
        cmd_valid = 1'b1;
        cmd_wr_rd = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        @(negedge clk);
        while (!cmd_ready && wcnt < 300) begin
            @(negedge clk);
            wcnt++;
        end
        chk("push_timeout", 32'(wcnt < 300), 32'd1);
        @(posedge clk);
        #2;
        cmd_valid = 1'b0;
        e.wr   = wr;
        e.err  = err;
        e.data = (wr || err) ? 16'h0000 : ref_mem[a];
        if (wr && !err) ref_mem[a] = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle();
        int g = 0;
        @(negedge clk);
        while ((busy || rsp_valid || exp_q.size() != 0) && g < 2000) begin
            @(negedge clk);
            g++;
        end
        chk("idle_timeout", 32'(g < 2000), 32'd1);
        @(posedge clk);
        #2;
    endtask

    task automatic wait_rsp_valid();
        int g = 0;
        @(negedge clk);
        while (!rsp_valid && g < 300) begin
            @(negedge clk);
            g++;
        end
        chk("rsp_valid_timeout", 32'(g < 300), 32'd1);
    endtask

    // Accept the held response and check the next command issues one cycle later.
    task automatic accept_then_issue(input logic [AW-1:0] a);
        rsp_ready = 1'b1;
        @(posedge clk);
        #2;
        @(negedge clk);
        chk("issue_gap_valid", 32'(valid), 32'd0);
        @(negedge clk);
        chk("issue_valid", 32'(valid), 32'd1);
        chk("issue_addr", 32'(addr), 32'(a));
        @(posedge clk);
        #2;
    endtask

    // Behavioural memory responder: ready after mem_lat cycles of valid.
    initial begin
        for (int i = 0; i < 16; i++) mdl_mem[i] = 16'h0000;
        forever begin
            @(negedge clk);
            if (!rst) begin
                ready = 1'b0; vcnt = 0; run_cnt = 0;
            end else begin
                if (valid) run_cnt++;
                else if (run_cnt != 0) begin last_run = run_cnt; run_cnt = 0; end
                if (ready) begin
                    ready = 1'b0; vcnt = 0;
                end else if (!valid) begin
                    vcnt = 0;
                end else if (!mem_stall) begin
                    vcnt++;
                    if (vcnt >= mem_lat) begin
                        ready = 1'b1;
                        if (wr_rd) mdl_mem[addr] = wdata;
                        else rdata = mdl_mem[addr];
                    end
                end
            end
        end
    end

    // Response monitor: stability while stalled, scoreboard compare on acceptance.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst || !rsp_valid) begin
                held = 1'b0;
            end else begin
                chk("valid_in_resp", 32'(valid), 32'd0);
                if (held) begin
                    chk("hold_wr_rd", 32'(rsp_wr_rd), 32'(s_wr));
                    chk("hold_rdata", 32'(rsp_rdata), 32'(s_data));
                    chk("hold_err", 32'(rsp_err), 32'(s_err));
                end
                if (rsp_ready) begin
                    chk("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        mon_e = exp_q.pop_front();
                        chk("rsp_wr_rd", 32'(rsp_wr_rd), 32'(mon_e.wr));
                        chk("rsp_rdata", 32'(rsp_rdata), 32'(mon_e.data));
                        chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
                    end
                    held = 1'b0;
                end else begin
                    held = 1'b1; s_wr = rsp_wr_rd; s_data = rsp_rdata; s_err = rsp_err;
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = 16'h0000;
        // Reset state
        repeat (3) @(posedge clk);
        #2;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("cmd_ready_lag", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #2;
        chk("cmd_ready_up", 32'(cmd_ready), 32'd1);

        // Single write, memory ready after 2 cycles
        mem_lat = 2;
        push_cmd(1'b1, 4'd3, 16'hA5A5, 1'b0, waited);
        @(negedge clk);
        chk("pop_latency_valid", 32'(valid), 32'd0);
        chk("busy_queued", 32'(busy), 32'd1);
        @(negedge clk);
        chk("issue_valid_w", 32'(valid), 32'd1);
        chk("issue_addr_w", 32'(addr), 32'd3);
        chk("issue_wr_rd_w", 32'(wr_rd), 32'd1);
        chk("issue_wdata_w", 32'(wdata), 32'h0000A5A5);
        wait_idle();
        chk("valid_run_2", 32'(last_run), 32'd2);

        // Write then read back
        mem_lat = 1;
        push_cmd(1'b1, 4'd5, 16'h1234, 1'b0, waited);
        push_cmd(1'b0, 4'd5, 16'h0000, 1'b0, waited);
        wait_idle();

        // FIFO full behind a slow transaction
        mem_lat = 10;
        push_cmd(1'b0, 4'd5, 16'h0000, 1'b0, waited);
        @(posedge clk);
        #2;
        for (int i = 0; i < 4; i++) push_cmd(1'b1, 4'(i), 16'h1000 + 16'(i), 1'b0, waited);
        @(negedge clk);
        chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
        push_cmd(1'b1, 4'd4, 16'h1004, 1'b0, waited);
        chk("fifth_waited", 32'(waited > 0), 32'd1);
        push_cmd(1'b0, 4'd0, 16'h0000, 1'b0, waited);
        push_cmd(1'b0, 4'd4, 16'h0000, 1'b0, waited);
        wait_idle();

        // Timeout with backpressured response, next command queued behind it
        mem_lat = 1;
        mem_stall = 1'b1;
        rsp_ready = 1'b0;
        push_cmd(1'b0, 4'd7, 16'h0000, 1'b1, waited);
        push_cmd(1'b1, 4'd9, 16'hBEEF, 1'b0, waited);
        wait_rsp_valid();
        @(negedge clk);
        chk("timeout_run_64", 32'(last_run), 32'd64);
        chk("timeout_err", 32'(rsp_err), 32'd1);
        chk("timeout_rdata", 32'(rsp_rdata), 32'd0);
        @(posedge clk);
        #2;
        mem_stall = 1'b0;
        accept_then_issue(4'd9);
        wait_idle();

        // Read response stalled 8 cycles
        rsp_ready = 1'b0;
        push_cmd(1'b0, 4'd5, 16'h0000, 1'b0, waited);
        push_cmd(1'b0, 4'd3, 16'h0000, 1'b0, waited);
        wait_rsp_valid();
        repeat (8) begin
            @(negedge clk);
            chk("stall_valid", 32'(valid), 32'd0);
            chk("stall_busy", 32'(busy), 32'd1);
        end
        @(posedge clk);
        #2;
        accept_then_issue(4'd3);
        wait_idle();

        // Reset in the middle of a request
        mem_lat = 20;
        push_cmd(1'b0, 4'd2, 16'h0000, 1'b0, waited);
        waited = 0;
        @(negedge clk);
        while (!valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("mid_valid_seen", 32'(valid), 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", 32'(valid), 32'd0);
        chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_cmd_ready", 32'(cmd_ready), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #2;
        mem_lat = 1;
        push_cmd(1'b0, 4'd5, 16'h0000, 1'b0, waited);
        wait_idle();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
